regfile_write_arbiter: RTL

- Shares the single register-file write port between two writeback requesters.
  - Requester 0: main pipeline writeback, high priority.
  - Requester 1: long-latency unit (multiply/divide/load-miss), low priority.
- Fixed priority to requester 0, with a starvation counter that forces a grant to requester 1 after MaxWait consecutive losses.
- Drives regWrite/writeRegister/writeData of the register file from registered outputs; writes to x0 are accepted but suppressed.

---
 rtl/regfile_write_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the main pipeline
// writeback (high priority) and a long-latency unit, with starvation forcing.
module regfile_write_arbiter #(
  parameter int WordCount = 32,
  parameter int DataWidth = 32,
  parameter int MaxWait   = 3,
  localparam int AW = $clog2(WordCount)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 req0Valid,
  input  logic [AW-1:0]        req0Reg,
  input  logic [DataWidth-1:0] req0Data,
  output logic                 req0Ready,
  input  logic                 req1Valid,
  input  logic [AW-1:0]        req1Reg,
  input  logic [DataWidth-1:0] req1Data,
  output logic                 req1Ready,
  output logic                 regWrite,
  output logic [AW-1:0]        writeRegister,
  output logic [DataWidth-1:0] writeData,
  output logic                 starved
);

  typedef enum logic [1:0] {GrantNone, Grant0, Grant1} grant_t;

  localparam logic [3:0] MaxWaitCount = 4'(MaxWait);

  grant_t     grant;
  logic [3:0] starveCount;

  assign starved = (starveCount == MaxWaitCount);

  // Readies are held low while reset is asserted so nothing is accepted
  // that the output register could not capture.
  always_comb begin
    // NOTE: assign every always_comb output a default first; a path that
    // leaves it unassigned would infer a latch.
    grant = GrantNone;
    if (!rst && !stall) begin
      if (req0Valid && !(req1Valid && starved)) grant = Grant0;
      else if (req1Valid)                       grant = Grant1;
    end
  end

  assign req0Ready = (grant == Grant0);
  assign req1Ready = (grant == Grant1);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      starveCount   <= '0;
    end else begin
      // x0 writes complete the handshake but never raise the write enable.
      unique case (grant)
        Grant0: begin
          regWrite      <= (req0Reg != '0);
          writeRegister <= req0Reg;
          writeData     <= req0Data;
        end
        Grant1: begin
          regWrite      <= (req1Reg != '0);
          writeRegister <= req1Reg;
          writeData     <= req1Data;
        end
        default: regWrite <= 1'b0;
      endcase

      // A waiting requester 1 keeps accruing losses even while stalled.
      if (req1Valid && !req1Ready)
        starveCount <= starved ? starveCount : starveCount + 4'd1;
      else
        starveCount <= '0;
    end
  end

endmodule
